// File: rtl/progmem_pkg.sv
// Shared definitions for the program-memory arbiter: default widths and the
// encoding of the last-granted-requester state.
package progmem_pkg;

    localparam int unsigned AW_DEFAULT = 8;
    localparam int unsigned DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        GntNone  = 2'd0,
        GntFetch = 2'd1,
        GntLoad  = 2'd2
    } last_gnt_e;

endpackage

// File: rtl/progmem_rdreg.sv
// Registered read-data/valid pair for one arbiter port. The valid bit follows
// the capture strobe by one cycle; data holds its last value otherwise.
module progmem_rdreg #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cap,
    input  logic [DW-1:0] din,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    // capture memory data on a read grant edge, pulse valid for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= cap;
            if (cap) begin
                data_q <= din;
            end
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/progmem_arbiter.sv
// Program-memory arbiter between the CPU fetch port and the loader/debug port.
// One access per cycle, read latency 1. Default build uses fixed loader
// priority with a starvation counter that forces a fetch grant after
// STARVE_MAX consecutive loader grants. Defining PROGMEM_RR_EN switches to
// round-robin on simultaneous requests and removes the counter.
module progmem_arbiter
    import progmem_pkg::*;
#(
    parameter int unsigned AW         = AW_DEFAULT,
    parameter int unsigned DW         = DW_DEFAULT,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic      f_win;
    logic      l_win;
    last_gnt_e last_gnt_q;
    last_gnt_e last_gnt_d;

`ifdef PROGMEM_RR_EN
    // round-robin: on a tie, grant the port that did not win last (loader first)
    always_comb begin
        f_win = 1'b0;
        l_win = 1'b0;
        if (f_req && l_req) begin
            if (last_gnt_q == GntLoad) begin
                f_win = 1'b1;
            end else begin
                l_win = 1'b1;
            end
        end else begin
            f_win = f_req;
            l_win = l_req;
        end
    end
`else
    localparam int unsigned CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;
    logic          starve_hit;

    assign starve_hit = (starve_q >= STARVE_LIM);

    // fixed priority: loader wins unless fetch has been starved long enough
    always_comb begin
        f_win = 1'b0;
        l_win = 1'b0;
        if (f_req && (!l_req || starve_hit)) begin
            f_win = 1'b1;
        end else if (l_req) begin
            l_win = 1'b1;
        end
    end

    // count loader grants that happen while fetch is waiting
    always_comb begin
        starve_d = starve_q;
        if (f_gnt || !f_req) begin
            starve_d = '0;
        end else if (l_gnt) begin
            starve_d = starve_q + CW'(1);
        end
    end

    // starvation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // grants are gated by reset so nothing is granted while rst_n is low
    assign f_gnt     = rst_n & f_win;
    assign l_gnt     = rst_n & l_win;
    assign mem_en    = f_gnt | l_gnt;
    assign mem_we    = l_gnt & l_we;
    assign mem_addr  = l_gnt ? l_addr : f_addr;
    assign mem_wdata = l_gnt ? l_wdata : '0;

    // remember which port won; idle cycles leave it untouched
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (f_gnt) begin
            last_gnt_d = GntFetch;
        end else if (l_gnt) begin
            last_gnt_d = GntLoad;
        end
    end

    // last-grant state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= GntNone;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    progmem_rdreg #(
        .DW (DW)
    ) u_f_rdreg (
        .clk   (clk),
        .rst_n (rst_n),
        .cap   (f_gnt),
        .din   (mem_rdata),
        .valid (f_rvalid),
        .data  (f_rdata)
    );

    // loader writes produce no read response
    progmem_rdreg #(
        .DW (DW)
    ) u_l_rdreg (
        .clk   (clk),
        .rst_n (rst_n),
        .cap   (l_gnt & ~l_we),
        .din   (mem_rdata),
        .valid (l_rvalid),
        .data  (l_rdata)
    );

endmodule

// File: tb/tb_progmem_arbiter.sv
// Self-checking bench for progmem_arbiter: directed cases with literal
// expectations plus randomized traffic compared each cycle against a
// behavioural model. Honours PROGMEM_RR_EN for the arbitration rule.
module tb_progmem_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          f_req, f_gnt, f_rvalid;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_rdata;
    logic          l_req, l_we, l_gnt, l_rvalid;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata, l_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    progmem_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .l_rvalid  (l_rvalid),
        .l_rdata   (l_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return 16'(16'hD0FE + i);
    endfunction

    // environment memory: combinational read, written on granted write edges
    logic [DW-1:0] mem [256];
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model state
    logic [DW-1:0] ref_mem [256];
    int            cnt;
    int            last;     // 0 none, 1 fetch, 2 loader
    logic          e_frv, e_lrv;
    logic [DW-1:0] e_frd, e_lrd;

    // compare process: mid-cycle, inputs and state are stable
    always @(negedge clk) begin
        logic efg, elg;
        if (!rst_n) begin
            check("rst f_gnt", f_gnt, 0);
            check("rst l_gnt", l_gnt, 0);
            check("rst mem_en", mem_en, 0);
            check("rst mem_we", mem_we, 0);
            check("rst f_rvalid", f_rvalid, 0);
            check("rst l_rvalid", l_rvalid, 0);
            check("rst f_rdata", f_rdata, 0);
            check("rst l_rdata", l_rdata, 0);
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
            cnt = 0; last = 0;
            e_frv = 1'b0; e_lrv = 1'b0; e_frd = '0; e_lrd = '0;
        end else begin
            efg = 1'b0;
            elg = 1'b0;
`ifdef PROGMEM_RR_EN
            if (f_req && l_req) begin
                if (last == 2) efg = 1'b1;
                else elg = 1'b1;
            end else begin
                efg = f_req;
                elg = l_req;
            end
`else
            if (f_req && (!l_req || cnt >= SMAX)) efg = 1'b1;
            else if (l_req) elg = 1'b1;
`endif
            check("m f_gnt", f_gnt, efg);
            check("m l_gnt", l_gnt, elg);
            check("m mem_en", mem_en, efg | elg);
            check("m mem_we", mem_we, elg & l_we);
            if (efg || elg) check("m mem_addr", mem_addr, elg ? l_addr : f_addr);
            if (elg && l_we) check("m mem_wdata", mem_wdata, l_wdata);
            check("m f_rvalid", f_rvalid, e_frv);
            check("m f_rdata", f_rdata, e_frd);
            check("m l_rvalid", l_rvalid, e_lrv);
            check("m l_rdata", l_rdata, e_lrd);
            // advance model to the next cycle
            e_frv = efg;
            if (efg) e_frd = ref_mem[f_addr];
            e_lrv = elg && !l_we;
            if (elg && !l_we) e_lrd = ref_mem[l_addr];
            if (elg && l_we) ref_mem[l_addr] = l_wdata;
            if (efg || !f_req) cnt = 0;
            else if (elg) cnt++;
            if (efg) last = 1;
            else if (elg) last = 2;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic fg_seen, lg_seen, expf;
        rst_n = 1'b1;
        f_req = 1'b0; f_addr = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset f_rvalid", f_rvalid, 0);
        check("reset f_gnt", f_gnt, 0);
        rst_n = 1'b1;

        // both requests held continuously from reset
        for (int i = 0; i < 10; i++) begin
            step();
            f_req = 1'b1; f_addr = 8'(8'h10 + i);
            l_req = 1'b1; l_we = 1'b0; l_addr = 8'h40;
            #1;
`ifdef PROGMEM_RR_EN
            expf = (i % 2) == 1;
`else
            expf = (i % 5) == 4;
`endif
            check("pattern f_gnt", f_gnt, expf);
            check("pattern l_gnt", l_gnt, !expf);
        end
        step();
        f_req = 1'b0; l_req = 1'b0;

        // single fetch read, latency 1
        step();
        f_req = 1'b1; f_addr = 8'h03;
        #1;
        check("fetch gnt", f_gnt, 1);
        check("fetch mem_addr", mem_addr, 8'h03);
        step();
        f_req = 1'b0;
        #1;
        check("fetch rvalid", f_rvalid, 1);
        check("fetch rdata", f_rdata, 16'hD101);

        // loader write
        step();
        l_req = 1'b1; l_we = 1'b1; l_addr = 8'h80; l_wdata = 16'h0010;
        #1;
        check("wr l_gnt", l_gnt, 1);
        check("wr mem_en", mem_en, 1);
        check("wr mem_we", mem_we, 1);
        check("wr mem_addr", mem_addr, 8'h80);
        check("wr mem_wdata", mem_wdata, 16'h0010);
        step();
        l_req = 1'b0; l_we = 1'b0;
        #1;
        check("wr no l_rvalid", l_rvalid, 0);

        // back-to-back fetches 0x00..0x08
        for (int i = 0; i < 10; i++) begin
            step();
            if (i < 9) begin
                f_req = 1'b1; f_addr = 8'(i);
            end else begin
                f_req = 1'b0;
            end
            #1;
            if (i > 0) begin
                check("b2b f_rvalid", f_rvalid, 1);
                check("b2b f_rdata", f_rdata, 16'hD0FE + 16'(i - 1));
            end
        end
        step();
        check("b2b end f_rvalid", f_rvalid, 0);

        // reset in a fetch grant cycle
        f_req = 1'b1; f_addr = 8'h05;
        #1;
        check("rstmid f_gnt pre", f_gnt, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid f_gnt", f_gnt, 0);
        check("rstmid mem_en", mem_en, 0);
        check("rstmid f_rdata", f_rdata, 0);
        check("rstmid f_rvalid", f_rvalid, 0);
        step();
        step();
        rst_n = 1'b1; f_req = 1'b0;
        #1;
        check("rstmid post f_rvalid", f_rvalid, 0);
        step();
        check("rstmid post2 f_rvalid", f_rvalid, 0);

        // randomized traffic; requesters hold until granted, sometimes cancel
        fg_seen = 1'b0;
        lg_seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (f_req && !fg_seen) begin
                if ($urandom_range(0, 15) == 0) f_req = 1'b0;
            end else begin
                f_req  = ($urandom_range(0, 3) != 0);
                f_addr = 8'($urandom);
            end
            if (l_req && !lg_seen) begin
                if ($urandom_range(0, 15) == 0) l_req = 1'b0;
            end else begin
                l_req   = ($urandom_range(0, 3) != 0);
                l_we    = 1'($urandom_range(0, 1));
                l_addr  = 8'($urandom);
                l_wdata = 16'($urandom);
            end
            #1;
            fg_seen = f_gnt;
            lg_seen = l_gnt;
        end
        step();
        f_req = 1'b0; l_req = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
